// File: rtl/varre_matriz_leds_pkg.sv
// Shared definitions for the LED-matrix display stage: copy-FSM state codes,
// default geometry and small decode helpers.
package varre_matriz_leds_pkg;

    localparam int LINHAS_PADRAO       = 16;
    localparam int COLUNAS_PADRAO      = 16;
    localparam int CICLOS_LINHA_PADRAO = 5000;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        ESPERA        = 4'd1,
        LE_LINHA      = 4'd2,
        ESPERA_MEM    = 4'd3,
        GRAVA_LINHA   = 4'd4,
        AGUARDA_TROCA = 4'd5,
        SINALIZA      = 4'd6
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'b1111;

    // Debug code of a state; anything outside the legal set reads as all ones.
    function automatic logic [3:0] codigo_db(input estado_t estado);
        logic [3:0] codigo;
        case (estado)
            INICIAL, ESPERA, LE_LINHA, ESPERA_MEM,
            GRAVA_LINHA, AGUARDA_TROCA, SINALIZA: codigo = estado;
            default:                              codigo = DB_ILEGAL;
        endcase
        return codigo;
    endfunction

    function automatic logic ocupado_em(input estado_t estado);
        logic ocupado;
        case (estado)
            LE_LINHA, ESPERA_MEM, GRAVA_LINHA, AGUARDA_TROCA: ocupado = 1'b1;
            default:                                          ocupado = 1'b0;
        endcase
        return ocupado;
    endfunction

endpackage

// File: rtl/varre_matriz_leds_if.sv
// Frame-memory read port: row address and read enable out, registered row data back.
interface varre_matriz_leds_if
    import varre_matriz_leds_pkg::*;
#(
    parameter int LINHAS  = LINHAS_PADRAO,
    parameter int COLUNAS = COLUNAS_PADRAO
);
    localparam int LW = (LINHAS > 1) ? $clog2(LINHAS) : 1;

    logic [LW-1:0]      endereco;
    logic               leitura;
    logic [COLUNAS-1:0] dado;

    modport master (output endereco, output leitura, input dado);
    modport slave  (input endereco, input leitura, output dado);
endinterface

// File: rtl/varre_matriz_leds_contador_varredura.sv
// Row-scan timebase: dwell counter t, row index r and the end-of-scan-frame strobe.
// Free-running from reset; reusable by any row-multiplexed display.
module contador_varredura #(
    parameter int  LINHAS       = 16,
    parameter int  CICLOS_LINHA = 5000,
    localparam int LW           = (LINHAS > 1) ? $clog2(LINHAS) : 1,
    localparam int TW           = (CICLOS_LINHA > 1) ? $clog2(CICLOS_LINHA) : 1
) (
    input  logic          clock,
    input  logic          reset,
    output logic [TW-1:0] t_o,
    output logic [LW-1:0] r_o,
    output logic          fim_varredura_o
);

    localparam logic [TW-1:0] T_ULTIMO = TW'(CICLOS_LINHA - 1);
    localparam logic [LW-1:0] R_ULTIMO = LW'(LINHAS - 1);

    logic [TW-1:0] t_q, t_d;
    logic [LW-1:0] r_q, r_d;
    logic          fim_linha_s;

    // Next dwell/row values: the row advances only when its dwell time wraps.
    always_comb begin
        t_d         = t_q;
        r_d         = r_q;
        fim_linha_s = (t_q == T_ULTIMO);
        if (fim_linha_s) begin
            t_d = {TW{1'b0}};
            if (r_q == R_ULTIMO) begin
                r_d = {LW{1'b0}};
            end else begin
                r_d = r_q + LW'(1);
            end
        end else begin
            t_d = t_q + TW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_q <= {TW{1'b0}};
            r_q <= {LW{1'b0}};
        end else begin
            t_q <= t_d;
            r_q <= r_d;
        end
    end

    assign t_o             = t_q;
    assign r_o             = r_q;
    assign fim_varredura_o = fim_linha_s && (r_q == R_ULTIMO);

endmodule

// File: rtl/varre_matriz_leds.sv
// LED-matrix display stage: copies each finished frame into a shadow buffer, swaps it
// onto the display buffer at a scan-frame boundary and row-multiplexes the display buffer.
module varre_matriz_leds
    import varre_matriz_leds_pkg::*;
#(
    parameter int  LINHAS       = LINHAS_PADRAO,
    parameter int  COLUNAS      = COLUNAS_PADRAO,
    parameter int  CICLOS_LINHA = CICLOS_LINHA_PADRAO,
    localparam int LW           = (LINHAS > 1) ? $clog2(LINHAS) : 1,
    localparam int TW           = (CICLOS_LINHA > 1) ? $clog2(CICLOS_LINHA) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fim_gera_frame,
    varre_matriz_leds_if.master mem_frame,
    output logic [LINHAS-1:0]   linha_ativa,
    output logic [COLUNAS-1:0]  colunas,
    output logic                ocupado,
    output logic                quadro_exibido,
    output logic [3:0]          db_estado
);

    localparam logic [LW-1:0]     K_ULTIMO = LW'(LINHAS - 1);
    localparam logic [LINHAS-1:0] LINHA0   = {{(LINHAS-1){1'b0}}, 1'b1};

    estado_t            estado_q, estado_d;
    logic [LW-1:0]      k_q, k_d;
    logic               pendente_q, pendente_d;
    logic [LW-1:0]      endereco_d;
    logic               grava_s;
    logic               troca_s;

    logic [COLUNAS-1:0] sombra_q    [LINHAS];
    logic [COLUNAS-1:0] exibicao_q  [LINHAS];

    logic [LW-1:0]      endereco_q;
    logic               leitura_q;
    logic               ocupado_q;
    logic               quadro_q;
    logic [3:0]         db_q;
    logic [LINHAS-1:0]  linha_ativa_q;
    logic [COLUNAS-1:0] colunas_q;

    logic [TW-1:0]      t_s;
    logic [LW-1:0]      r_s;
    logic               fim_varredura_s;

    contador_varredura #(
        .LINHAS       (LINHAS),
        .CICLOS_LINHA (CICLOS_LINHA)
    ) u_contador (
        .clock           (clock),
        .reset           (reset),
        .t_o             (t_s),
        .r_o             (r_s),
        .fim_varredura_o (fim_varredura_s)
    );

    // Copy FSM next state. A frame request seen while busy or signalling is merged
    // into a single pending flag that restarts the copy from row 0.
    always_comb begin
        estado_d   = estado_q;
        k_d        = k_q;
        pendente_d = pendente_q;
        grava_s    = 1'b0;
        troca_s    = 1'b0;
        case (estado_q)
            INICIAL: estado_d = ESPERA;
            ESPERA: begin
                k_d = {LW{1'b0}};
                if (fim_gera_frame || pendente_q) begin
                    estado_d   = LE_LINHA;
                    pendente_d = 1'b0;
                end else begin
                    estado_d   = ESPERA;
                end
            end
            LE_LINHA: begin
                estado_d   = ESPERA_MEM;
                pendente_d = pendente_q || fim_gera_frame;
            end
            ESPERA_MEM: begin
                estado_d   = GRAVA_LINHA;
                pendente_d = pendente_q || fim_gera_frame;
            end
            GRAVA_LINHA: begin
                grava_s    = 1'b1;
                pendente_d = pendente_q || fim_gera_frame;
                if (k_q == K_ULTIMO) begin
                    estado_d = AGUARDA_TROCA;
                end else begin
                    k_d      = k_q + LW'(1);
                    estado_d = LE_LINHA;
                end
            end
            AGUARDA_TROCA: begin
                pendente_d = pendente_q || fim_gera_frame;
                if (fim_varredura_s) begin
                    troca_s  = 1'b1;
                    estado_d = SINALIZA;
                end else begin
                    estado_d = AGUARDA_TROCA;
                end
            end
            SINALIZA: begin
                estado_d   = ESPERA;
                pendente_d = pendente_q || fim_gera_frame;
            end
            default: begin
                estado_d = INICIAL;
                k_d      = {LW{1'b0}};
            end
        endcase
        if (estado_d == LE_LINHA || estado_d == ESPERA_MEM) begin
            endereco_d = k_d;
        end else begin
            endereco_d = {LW{1'b0}};
        end
    end

    // FSM state plus Moore outputs, registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            k_q        <= {LW{1'b0}};
            pendente_q <= 1'b0;
            endereco_q <= {LW{1'b0}};
            leitura_q  <= 1'b0;
            ocupado_q  <= 1'b0;
            quadro_q   <= 1'b0;
            db_q       <= 4'd0;
        end else begin
            estado_q   <= estado_d;
            k_q        <= k_d;
            pendente_q <= pendente_d;
            endereco_q <= endereco_d;
            leitura_q  <= (estado_d == LE_LINHA);
            ocupado_q  <= ocupado_em(estado_d);
            quadro_q   <= (estado_d == SINALIZA);
            db_q       <= codigo_db(estado_d);
        end
    end

    // Shadow fill and whole-frame swap; the swap only happens on a scan-frame boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINHAS; i++) begin
                sombra_q[i]   <= {COLUNAS{1'b0}};
                exibicao_q[i] <= {COLUNAS{1'b0}};
            end
        end else begin
            if (grava_s) begin
                sombra_q[k_q] <= mem_frame.dado;
            end
            if (troca_s) begin
                for (int i = 0; i < LINHAS; i++) begin
                    exibicao_q[i] <= sombra_q[i];
                end
            end
        end
    end

    // Row/column drive, blanked on the first dwell cycle of every row against ghosting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            linha_ativa_q <= LINHA0;
            colunas_q     <= {COLUNAS{1'b0}};
        end else begin
            linha_ativa_q <= LINHA0 << r_s;
            colunas_q     <= (t_s == {TW{1'b0}}) ? {COLUNAS{1'b0}} : exibicao_q[r_s];
        end
    end

    assign mem_frame.endereco = endereco_q;
    assign mem_frame.leitura  = leitura_q;
    assign linha_ativa        = linha_ativa_q;
    assign colunas            = colunas_q;
    assign ocupado            = ocupado_q;
    assign quadro_exibido     = quadro_q;
    assign db_estado          = db_q;

endmodule
